branch_resolve_queue: RTL and testbench

- Tracks every predicted branch or jump from fetch until execute resolves it.
- Fetch pushes {pc, predicted direction, BHT counter snapshot}. Execute resolves the oldest entry with the actual outcome.
- The block produces the BHT write port (update index, new 2-bit counter) and a registered mispredict/redirect to the fetch PC mux.
- It is the write/update side of the branch predictor. It replaces the combinational update path that re-reads the counter at execute time.

---
 rtl/branch_resolve_queue_pkg.sv | 36 +++
 rtl/branch_resolve_queue_fifo.sv | 50 +++++
 rtl/branch_resolve_queue.sv | 114 +++++++++++
 tb/tb_branch_resolve_queue.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue: entry bundle, FSM states,
// and the saturating BHT counter update.
package bp_types;

    localparam int CNT_WIDTH = 2;

    localparam logic [CNT_WIDTH-1:0] WEAK_NT  = 2'b01;
    localparam logic [CNT_WIDTH-1:0] STRONG_T = 2'b11;

    typedef struct packed {
        logic [31:0]          pc;
        logic                 pred;
        logic [CNT_WIDTH-1:0] cnt;
    } brq_entry_t;

    typedef enum logic {
        ACTIVE  = 1'b0,
        RECOVER = 1'b1
    } brq_state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_update(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 br_en,
        input logic                 jump
    );
        logic [CNT_WIDTH-1:0] r;
        if (jump)
            r = STRONG_T;
        else if (br_en)
            r = (cnt == STRONG_T) ? cnt : cnt + 1'b1;
        else
            r = (cnt == '0) ? cnt : cnt - 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/branch_resolve_queue_fifo.sv
// Circular entry store for the branch resolve queue; clear wins over
// push and pop.
module brq_fifo
    import bp_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       wr,
    input  brq_entry_t wdata,
    input  logic       rd,
    output brq_entry_t rdata,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(DEPTH);

    brq_entry_t   mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[head];

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                mem[tail] <= wdata;
                tail      <= tail + 1'b1;
            end
            if (rd)
                head <= head + 1'b1;
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: BHT write port and registered redirect.
// Optional BRQ_STATS_EN adds resolve/mispredict counters.
module branch_resolve_queue
    import bp_types::*;
#(
    parameter int DEPTH   = 4,
    parameter int S_INDEX = 10,
    parameter int CNT_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [31:0]        push_pc,
    input  logic               push_pred,
    input  logic [CNT_W-1:0]   push_cnt,
    output logic               full,
    output logic               empty,
    input  logic               resolve,
    input  logic               res_br_en,
    input  logic               res_jump,
    input  logic [31:0]        res_target,
    input  logic               flush,
    output logic               bht_load,
    output logic [S_INDEX-1:0] bht_windex,
    output logic [CNT_W-1:0]   bht_datain,
    output logic               mispredict,
`ifdef BRQ_STATS_EN
    output logic [31:0]        stat_resolved,
    output logic [31:0]        stat_mispredict,
`endif
    output logic [31:0]        redirect_pc
);

    brq_state_t state, state_nx;
    brq_entry_t head, wentry;
    logic       taken, do_pop, do_push, mis, clear;

    assign taken = res_br_en | res_jump;
    assign do_pop = resolve && !empty && state == ACTIVE && !flush;
    assign mis = do_pop && (head.pred != taken);
    // a mispredict squashes everything younger, including this cycle's push
    assign do_push = push && state == ACTIVE && !flush && !mis
                     && (!full || do_pop);
    assign clear = flush | mis;

    assign wentry.pc   = push_pc;
    assign wentry.pred = push_pred;
    assign wentry.cnt  = push_cnt;

    brq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .wr    (do_push),
        .wdata (wentry),
        .rd    (do_pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nx = state;
        if (flush)
            state_nx = ACTIVE;
        else if (state == RECOVER)
            state_nx = ACTIVE;
        else if (mis)
            state_nx = RECOVER;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ACTIVE;
            bht_load    <= 1'b0;
            bht_windex  <= '0;
            bht_datain  <= '0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            state      <= state_nx;
            bht_load   <= do_pop;
            mispredict <= mis;
            if (do_pop) begin
                bht_windex  <= head.pc[S_INDEX-1:0];
                bht_datain  <= sat_update(head.cnt, res_br_en, res_jump);
                redirect_pc <= taken ? res_target : head.pc + 32'd4;
            end
        end
    end

`ifdef BRQ_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else begin
            if (do_pop)
                stat_resolved <= stat_resolved + 1'b1;
            if (mis)
                stat_mispredict <= stat_mispredict + 1'b1;
        end
    end
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n)
            assert (!(resolve && empty))
            else $warning("brq: resolve while empty ignored");
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue.
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push;
    logic [31:0] push_pc;
    logic        push_pred;
    logic [1:0]  push_cnt;
    logic        full, empty;
    logic        resolve, res_br_en, res_jump;
    logic [31:0] res_target;
    logic        flush;
    logic        bht_load;
    logic [9:0]  bht_windex;
    logic [1:0]  bht_datain;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BRQ_STATS_EN
    logic [31:0] stat_resolved, stat_mispredict;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_resolve_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_pc     (push_pc),
        .push_pred   (push_pred),
        .push_cnt    (push_cnt),
        .full        (full),
        .empty       (empty),
        .resolve     (resolve),
        .res_br_en   (res_br_en),
        .res_jump    (res_jump),
        .res_target  (res_target),
        .flush       (flush),
        .bht_load    (bht_load),
        .bht_windex  (bht_windex),
        .bht_datain  (bht_datain),
        .mispredict  (mispredict),
`ifdef BRQ_STATS_EN
        .stat_resolved   (stat_resolved),
        .stat_mispredict (stat_mispredict),
`endif
        .redirect_pc (redirect_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 0; resolve = 0; flush = 0;
        res_br_en = 0; res_jump = 0; res_target = 0;
    endtask

    task automatic do_push(input logic [31:0] pc, input logic pr,
                           input logic [1:0] c);
        idle();
        push = 1; push_pc = pc; push_pred = pr; push_cnt = c;
        tick();
        idle();
    endtask

    task automatic do_resolve(input logic be, input logic j,
                              input logic [31:0] t);
        idle();
        resolve = 1; res_br_en = be; res_jump = j; res_target = t;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        push_pc = 0; push_pred = 0; push_cnt = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || bht_load !== 1'b0 ||
            mispredict !== 1'b0 || redirect_pc !== 32'd0 ||
            bht_windex !== 10'd0 || bht_datain !== 2'd0) begin
            failures++;
            $display("FAIL reset: e=%b f=%b ld=%b mp=%b rp=%h wi=%h di=%b",
                     empty, full, bht_load, mispredict, redirect_pc,
                     bht_windex, bht_datain);
        end
    endtask

    task automatic test_not_taken();
        do_push(32'h100, 1'b0, 2'b01);
        do_resolve(1'b0, 1'b0, 32'h0);
        checks++;
        if (bht_load !== 1'b1 || bht_windex !== 10'h100 ||
            bht_datain !== 2'b00 || mispredict !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL not_taken: ld=%b wi=%h di=%b mp=%b e=%b want 1 100 00 0 1",
                     bht_load, bht_windex, bht_datain, mispredict, empty);
        end
        tick();
        checks++;
        if (bht_load !== 1'b0) begin
            failures++;
            $display("FAIL load_pulse: ld=%b want 0", bht_load);
        end
    endtask

    task automatic test_mispredict_taken();
        do_push(32'h204, 1'b0, 2'b01);
        do_resolve(1'b1, 1'b0, 32'h300);
        checks++;
        if (bht_load !== 1'b1 || bht_windex !== 10'h204 ||
            bht_datain !== 2'b10 || mispredict !== 1'b1 ||
            redirect_pc !== 32'h300 || empty !== 1'b1) begin
            failures++;
            $display("FAIL mp_taken: ld=%b wi=%h di=%b mp=%b rp=%h e=%b",
                     bht_load, bht_windex, bht_datain, mispredict,
                     redirect_pc, empty);
        end
        do_push(32'h500, 1'b1, 2'b11);
        checks++;
        if (empty !== 1'b1 || mispredict !== 1'b0 || bht_load !== 1'b0) begin
            failures++;
            $display("FAIL recover_push: e=%b mp=%b ld=%b want 1 0 0",
                     empty, mispredict, bht_load);
        end
    endtask

    task automatic test_mispredict_not_taken();
        do_push(32'h40, 1'b1, 2'b11);
        do_resolve(1'b0, 1'b0, 32'h999);
        checks++;
        if (bht_datain !== 2'b10 || mispredict !== 1'b1 ||
            redirect_pc !== 32'h44 || bht_windex !== 10'h40) begin
            failures++;
            $display("FAIL mp_not_taken: di=%b mp=%b rp=%h wi=%h want 10 1 44 040",
                     bht_datain, mispredict, redirect_pc, bht_windex);
        end
        tick();
    endtask

    task automatic test_full();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h20; exp_pc[1] = 32'h30;
        exp_pc[2] = 32'h40; exp_pc[3] = 32'h60;
        for (int i = 1; i <= 4; i++)
            do_push(32'(i * 16), 1'b0, 2'b01);
        checks++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL fill: full=%b empty=%b want 1 0", full, empty);
        end
        do_push(32'h50, 1'b0, 2'b01);
        checks++;
        if (full !== 1'b1) begin
            failures++;
            $display("FAIL drop5: full=%b want 1", full);
        end
        idle();
        push = 1; push_pc = 32'h60; push_pred = 0; push_cnt = 2'b10;
        resolve = 1; res_br_en = 0;
        tick();
        idle();
        checks++;
        if (full !== 1'b1 || bht_load !== 1'b1 || bht_windex !== 10'h10 ||
            bht_datain !== 2'b00) begin
            failures++;
            $display("FAIL push_pop_full: full=%b ld=%b wi=%h di=%b want 1 1 010 00",
                     full, bht_load, bht_windex, bht_datain);
        end
        for (int i = 0; i < 4; i++) begin
            do_resolve(1'b0, 1'b0, 32'h0);
            checks++;
            if (bht_windex !== exp_pc[i][9:0] || mispredict !== 1'b0 ||
                bht_load !== 1'b1) begin
                failures++;
                $display("FAIL order%0d: wi=%h mp=%b ld=%b want %h 0 1",
                         i, bht_windex, mispredict, bht_load, exp_pc[i][9:0]);
            end
        end
        checks++;
        if (empty !== 1'b1 || bht_datain !== 2'b01) begin
            failures++;
            $display("FAIL drain: e=%b di=%b want 1 01", empty, bht_datain);
        end
    endtask

    task automatic test_jump_flush();
        do_push(32'h80, 1'b0, 2'b00);
        do_resolve(1'b0, 1'b1, 32'h1000);
        checks++;
        if (bht_datain !== 2'b11 || mispredict !== 1'b1 ||
            redirect_pc !== 32'h1000) begin
            failures++;
            $display("FAIL jump: di=%b mp=%b rp=%h want 11 1 1000",
                     bht_datain, mispredict, redirect_pc);
        end
        tick();
        for (int i = 0; i < 3; i++)
            do_push(32'h900 + 32'(i * 4), 1'b1, 2'b11);
        idle();
        flush = 1; resolve = 1; res_br_en = 0;
        push = 1; push_pc = 32'hA00;
        tick();
        idle();
        checks++;
        if (bht_load !== 1'b0 || mispredict !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL flush: ld=%b mp=%b e=%b want 0 0 1",
                     bht_load, mispredict, empty);
        end
    endtask

    task automatic test_reset_mid();
        do_push(32'h120, 1'b0, 2'b10);
        do_push(32'h124, 1'b1, 2'b01);
        do_resolve(1'b1, 1'b0, 32'h0);
        idle();
        rst_n = 0; resolve = 1; res_br_en = 0;
        tick();
        idle();
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || bht_load !== 1'b0 ||
            mispredict !== 1'b0 || redirect_pc !== 32'd0 ||
            bht_windex !== 10'd0 || bht_datain !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid: e=%b ld=%b mp=%b rp=%h wi=%h di=%b",
                     empty, bht_load, mispredict, redirect_pc,
                     bht_windex, bht_datain);
        end
        rst_n = 1;
        do_resolve(1'b1, 1'b0, 32'h0);
        checks++;
        if (bht_load !== 1'b0 || mispredict !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL resolve_empty: ld=%b mp=%b e=%b want 0 0 1",
                     bht_load, mispredict, empty);
        end
`ifdef BRQ_STATS_EN
        checks++;
        if (stat_resolved !== 32'd0 || stat_mispredict !== 32'd0) begin
            failures++;
            $display("FAIL stats_reset: r=%0d m=%0d want 0 0",
                     stat_resolved, stat_mispredict);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_not_taken();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_full();
        test_jump_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
